// File: rtl/int_vect_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: register offsets,
// FSM state codes and sizing constants.
package int_vect_ctrl_pkg;

    localparam logic [3:0] INTC_CTRL = 4'd0;
    localparam logic [3:0] INTC_MASK = 4'd1;
    localparam logic [3:0] INTC_PEND = 4'd2;
    localparam logic [3:0] INTC_STAT = 4'd3;

    // Index width is sized for the largest supported source count (32).
    localparam int IDX_W = 5;

    // A source stays excluded for the pulse cycle plus this many cycles after it.
    localparam logic [1:0] BLANK_CYCLES = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: index 0 is the highest priority source.
module int_prio_enc
    import int_vect_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     req_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IDX_W'(i);
        end
    end

endmodule

// File: rtl/int_vect_ctrl.sv
// Vectored interrupt controller: masks and prioritises level interrupt lines,
// raises one vectored request to the core and acks the granted source via int_rst.
module int_vect_ctrl
    import int_vect_ctrl_pkg::*;
#(
    parameter int ADDRESS           = 0,
    parameter int BUS_ADDR_DATA_LEN = 16,
    parameter int NUM_INT           = 8,
    parameter int VECT_WIDTH        = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr_w,
    input  logic                         rd_w,
    input  logic [31:0]                  bus_in,
    output logic [31:0]                  bus_out,
    output logic                         req_bus,
    input  logic [NUM_INT-1:0]           int_src,
    output logic [NUM_INT-1:0]           int_rst,
    output logic                         cpu_int_req,
    output logic [VECT_WIDTH-1:0]        cpu_int_vect,
    input  logic                         cpu_int_ack,
    input  logic                         cpu_reti
);

    localparam int AW = BUS_ADDR_DATA_LEN + 1;
    localparam logic [AW-1:0] WIN_LO = AW'(ADDRESS);
    localparam logic [AW-1:0] WIN_HI = WIN_LO + AW'(16);

    intc_state_e                state_q;
    logic [IDX_W-1:0]           idx_q;
    logic                       req_q;
    logic [VECT_WIDTH-1:0]      vect_q;
    logic                       gie_q;
    logic [NUM_INT-1:0]         mask_q;
    logic [NUM_INT-1:0]         int_rst_q, int_rst_d;
    logic [NUM_INT-1:0][1:0]    blank_cnt_q;

    logic [3:0]                 offs;
    logic                       wr_en;
    logic [NUM_INT-1:0]         blank;
    logic [NUM_INT-1:0]         pend;
    logic [31:0]                pend_w;
    logic [31:0]                ack_oh;
    logic                       win_vld;
    logic [IDX_W-1:0]           win_idx;
    logic                       unused_bus;

    assign req_bus = ({1'b0, addr} >= WIN_LO) && ({1'b0, addr} < WIN_HI);
    assign offs    = addr[3:0];
    assign wr_en   = wr_w && req_bus;
    assign unused_bus = ^bus_in;

    always_comb begin
        for (int i = 0; i < NUM_INT; i++) begin
            blank[i] = int_rst_q[i] || (blank_cnt_q[i] != 2'd0);
        end
    end

    assign pend   = int_src & mask_q & {NUM_INT{gie_q}} & ~blank;
    assign pend_w = 32'(pend);
    assign ack_oh = 32'd1 << idx_q;

    int_prio_enc #(.N(NUM_INT)) u_prio (
        .req_i   (pend),
        .valid_o (win_vld),
        .idx_o   (win_idx)
    );

    // Software clear and FSM ack share one pulse register; coincident hits merge.
    always_comb begin
        int_rst_d = '0;
        if (wr_en && offs == INTC_PEND) int_rst_d = bus_in[NUM_INT-1:0];
        if (state_q == ST_REQ && cpu_int_ack) int_rst_d = int_rst_d | ack_oh[NUM_INT-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            vect_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (win_vld) begin
                        state_q <= ST_REQ;
                        idx_q   <= win_idx;
                        req_q   <= 1'b1;
                        vect_q  <= VECT_WIDTH'(win_idx) + VECT_WIDTH'(1);
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over the granted line dropping.
                    if (cpu_int_ack) begin
                        state_q <= ST_SERVICE;
                        req_q   <= 1'b0;
                    end else if (!pend_w[idx_q]) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        vect_q  <= '0;
                    end
                end
                ST_SERVICE: begin
                    if (cpu_reti) begin
                        state_q <= ST_IDLE;
                        vect_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    vect_q  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gie_q       <= 1'b0;
            mask_q      <= '0;
            int_rst_q   <= '0;
            blank_cnt_q <= '0;
        end else begin
            if (wr_en && offs == INTC_CTRL) gie_q  <= bus_in[0];
            if (wr_en && offs == INTC_MASK) mask_q <= bus_in[NUM_INT-1:0];
            int_rst_q <= int_rst_d;
            for (int i = 0; i < NUM_INT; i++) begin
                if (int_rst_q[i])
                    blank_cnt_q[i] <= BLANK_CYCLES;
                else if (blank_cnt_q[i] != 2'd0)
                    blank_cnt_q[i] <= blank_cnt_q[i] - 2'd1;
            end
        end
    end

    always_comb begin
        bus_out = '0;
        if (rd_w && req_bus) begin
            case (offs)
                INTC_CTRL: bus_out = {31'b0, gie_q};
                INTC_MASK: bus_out = 32'(mask_q);
                INTC_PEND: bus_out = 32'(int_src & mask_q);
                INTC_STAT: bus_out = 32'({idx_q, 6'b0, state_q});
                default:   bus_out = '0;
            endcase
        end
    end

    assign int_rst      = int_rst_q;
    assign cpu_int_req  = req_q;
    assign cpu_int_vect = vect_q;

endmodule
